usb_setup_capture: RTL and testbench

USB_SETUP_CAPTURE -- requirements
Module: usb_setup_capture

---
 rtl/usb_setup_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_usb_setup_capture.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_setup_capture.sv
// usb_setup_capture
//    Captures the 8-byte SETUP packet of a USB control transfer on endpoint 0,
//    validates it, and publishes the decoded request fields. Tracks a
//    SET_ADDRESS request and applies the new device address after the
//    status stage (IN on endpoint 0) completes successfully.
//
// Ports
//    clk_48             48 MHz clock, rising edge
//    rst                asynchronous active-high reset
//    usb_rst            USB bus reset, sampled synchronously
//    transaction_active core transaction in progress
//    direction_in       1 = IN (device to host)
//    setup              current transaction is SETUP
//    endpoint[3:0]      endpoint of the current transaction
//    data_out[7:0]      received byte
//    data_strobe        rising edge marks a new data_out byte
//    success            transaction completed (CRC + handshake good)
//    setup_valid        one-clock pulse, request fields updated
//    setup_error        one-clock pulse, malformed/failed SETUP discarded
//    bm_request_type, b_request, w_value, w_index, w_length  decoded fields
//    usb_address[6:0]   device address for the core
//    addr_pending       SET_ADDRESS accepted, not yet applied
module usb_setup_capture (
   input  logic        clk_48,
   input  logic        rst,
   input  logic        usb_rst,
   input  logic        transaction_active,
   input  logic        direction_in,
   input  logic        setup,
   input  logic [3:0]  endpoint,
   input  logic [7:0]  data_out,
   input  logic        data_strobe,
   input  logic        success,
   output logic        setup_valid,
   output logic        setup_error,
   output logic [7:0]  bm_request_type,
   output logic [7:0]  b_request,
   output logic [15:0] w_value,
   output logic [15:0] w_index,
   output logic [15:0] w_length,
   output logic [6:0]  usb_address,
   output logic        addr_pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      CHECK   = 2'd2
   } state_t;

   localparam logic [7:0] REQ_SET_ADDRESS = 8'h05;

   state_t          state_q, state_d;
   logic            strobe_prev_q, strobe_prev_d;
   logic            ta_prev_q, ta_prev_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            ok_q, ok_d;
   logic [7:0][7:0] buf_q, buf_d;
   logic            setup_valid_q, setup_valid_d;
   logic            setup_error_q, setup_error_d;
   logic [7:0]      bm_q, bm_d;
   logic [7:0]      breq_q, breq_d;
   logic [15:0]     wval_q, wval_d;
   logic [15:0]     widx_q, widx_d;
   logic [15:0]     wlen_q, wlen_d;
   logic [6:0]      usb_address_q, usb_address_d;
   logic            addr_pending_q, addr_pending_d;
   logic [6:0]      pending_addr_q, pending_addr_d;

   logic byte_edge;
   logic ta_rise;
   logic ta_fall;
   logic setup_ep0;
   logic status_ok;

   always_comb begin
      state_d        = state_q;
      strobe_prev_d  = data_strobe;
      ta_prev_d      = transaction_active;
      cnt_d          = cnt_q;
      ovf_d          = ovf_q;
      ok_d           = ok_q;
      buf_d          = buf_q;
      setup_valid_d  = 1'b0;
      setup_error_d  = 1'b0;
      bm_d           = bm_q;
      breq_d         = breq_q;
      wval_d         = wval_q;
      widx_d         = widx_q;
      wlen_d         = wlen_q;
      usb_address_d  = usb_address_q;
      addr_pending_d = addr_pending_q;
      pending_addr_d = pending_addr_q;

      byte_edge = data_strobe & ~strobe_prev_q;
      ta_rise   = transaction_active & ~ta_prev_q;
      ta_fall   = ~transaction_active & ta_prev_q;
      setup_ep0 = setup & ~direction_in & (endpoint == 4'd0);
      status_ok = addr_pending_q & success & direction_in & ~setup &
                  (endpoint == 4'd0);

      // Status stage of the SET_ADDRESS transfer: the new address only takes
      // effect once the host has acknowledged the zero-length IN.
      if (status_ok) begin
         usb_address_d  = pending_addr_q;
         addr_pending_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ta_rise && setup_ep0) begin
               state_d        = CAPTURE;
               cnt_d          = 4'd0;
               ovf_d          = 1'b0;
               ok_d           = 1'b0;
               // A new SETUP aborts any SET_ADDRESS still awaiting status.
               addr_pending_d = 1'b0;
            end
         end

         CAPTURE: begin
            // Byte is taken first so a byte arriving with success still counts.
            if (byte_edge) begin
               if (cnt_q < 4'd8) begin
                  buf_d[cnt_q[2:0]] = data_out;
               end else begin
                  ovf_d = 1'b1;
               end
               if (cnt_q != 4'd9) begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            if (success) begin
               state_d = CHECK;
               ok_d    = 1'b1;
            end else if (ta_fall) begin
               state_d = CHECK;
               ok_d    = 1'b0;
            end
         end

         CHECK: begin
            state_d = IDLE;
            if (ok_q && (cnt_q == 4'd8) && !ovf_q) begin
               setup_valid_d = 1'b1;
               bm_d          = buf_q[0];
               breq_d        = buf_q[1];
               wval_d        = {buf_q[3], buf_q[2]};
               widx_d        = {buf_q[5], buf_q[4]};
               wlen_d        = {buf_q[7], buf_q[6]};
               if ((buf_q[0] == 8'h00) && (buf_q[1] == REQ_SET_ADDRESS)) begin
                  addr_pending_d = 1'b1;
                  pending_addr_d = buf_q[2][6:0];
               end
            end else begin
               setup_error_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase

      // Bus reset wins over everything; partial packets vanish silently.
      if (usb_rst) begin
         state_d        = IDLE;
         usb_address_d  = 7'd0;
         addr_pending_d = 1'b0;
         setup_valid_d  = 1'b0;
         setup_error_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_48 or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         // Edge detectors come up "high" so a transaction or strobe already
         // in flight at reset release is not mistaken for a new one.
         strobe_prev_q  <= 1'b1;
         ta_prev_q      <= 1'b1;
         cnt_q          <= 4'd0;
         ovf_q          <= 1'b0;
         ok_q           <= 1'b0;
         buf_q          <= '0;
         setup_valid_q  <= 1'b0;
         setup_error_q  <= 1'b0;
         bm_q           <= 8'd0;
         breq_q         <= 8'd0;
         wval_q         <= 16'd0;
         widx_q         <= 16'd0;
         wlen_q         <= 16'd0;
         usb_address_q  <= 7'd0;
         addr_pending_q <= 1'b0;
         pending_addr_q <= 7'd0;
      end else begin
         state_q        <= state_d;
         strobe_prev_q  <= strobe_prev_d;
         ta_prev_q      <= ta_prev_d;
         cnt_q          <= cnt_d;
         ovf_q          <= ovf_d;
         ok_q           <= ok_d;
         buf_q          <= buf_d;
         setup_valid_q  <= setup_valid_d;
         setup_error_q  <= setup_error_d;
         bm_q           <= bm_d;
         breq_q         <= breq_d;
         wval_q         <= wval_d;
         widx_q         <= widx_d;
         wlen_q         <= wlen_d;
         usb_address_q  <= usb_address_d;
         addr_pending_q <= addr_pending_d;
         pending_addr_q <= pending_addr_d;
      end
   end

   assign setup_valid     = setup_valid_q;
   assign setup_error     = setup_error_q;
   assign bm_request_type = bm_q;
   assign b_request       = breq_q;
   assign w_value         = wval_q;
   assign w_index         = widx_q;
   assign w_length        = wlen_q;
   assign usb_address     = usb_address_q;
   assign addr_pending    = addr_pending_q;

endmodule

// File: tb/tb_usb_setup_capture.sv
// Testbench for usb_setup_capture: directed + randomized SETUP traffic,
// scoreboard of expected pulses checked by an independent monitor.
module tb_usb_setup_capture;

   logic        clk_48 = 1'b0;
   logic        rst = 1'b1;
   logic        usb_rst = 1'b0;
   logic        transaction_active = 1'b0;
   logic        direction_in = 1'b0;
   logic        setup = 1'b0;
   logic [3:0]  endpoint = 4'd0;
   logic [7:0]  data_out = 8'd0;
   logic        data_strobe = 1'b0;
   logic        success = 1'b0;
   logic        setup_valid, setup_error;
   logic [7:0]  bm_request_type, b_request;
   logic [15:0] w_value, w_index, w_length;
   logic [6:0]  usb_address;
   logic        addr_pending;

   usb_setup_capture dut (
      .clk_48(clk_48), .rst(rst), .usb_rst(usb_rst),
      .transaction_active(transaction_active), .direction_in(direction_in),
      .setup(setup), .endpoint(endpoint), .data_out(data_out),
      .data_strobe(data_strobe), .success(success),
      .setup_valid(setup_valid), .setup_error(setup_error),
      .bm_request_type(bm_request_type), .b_request(b_request),
      .w_value(w_value), .w_index(w_index), .w_length(w_length),
      .usb_address(usb_address), .addr_pending(addr_pending)
   );

   always #10 clk_48 = ~clk_48;

   int cyc = 0;
   always @(posedge clk_48) cyc <= cyc + 1;

   typedef struct {
      bit          is_valid;
      logic [7:0]  bm, br;
      logic [15:0] wv, wi, wl;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_bm = 0, m_br = 0;
   logic [15:0] m_wv = 0, m_wi = 0, m_wl = 0;
   logic [6:0]  m_addr = 0, m_pend_addr = 0;
   bit          m_pending = 0;

   logic [7:0] pkt [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_48);
      #1;
   endtask

   // Expected outcome of a SETUP on ep0: valid iff completed with success
   // and exactly 8 bytes seen.
   task automatic push_exp(input bit good, input int n, input int at_cyc);
      exp_t e;
      e.is_valid = good && (n == 8);
      if (e.is_valid) begin
         m_bm = pkt[0];
         m_br = pkt[1];
         m_wv = {pkt[3], pkt[2]};
         m_wi = {pkt[5], pkt[4]};
         m_wl = {pkt[7], pkt[6]};
         if (m_bm == 8'h00 && m_br == 8'h05) begin
            m_pending   = 1;
            m_pend_addr = m_wv[6:0];
         end
      end
      e.bm = m_bm; e.br = m_br; e.wv = m_wv; e.wi = m_wi; e.wl = m_wl;
      e.cyc = at_cyc;
      sb.push_back(e);
   endtask

   task automatic do_setup(input int n, input int ep, input int hold,
                           input bit good, input bit same_clk);
      bit done = 0;
      transaction_active = 1; setup = 1; direction_in = 0; endpoint = ep[3:0];
      tick();
      if (ep == 0) m_pending = 0;
      for (int i = 0; i < n; i++) begin
         data_out = pkt[i];
         data_strobe = 1;
         if (i == n - 1 && good && same_clk) begin
            success = 1;
            if (ep == 0) push_exp(1, n, cyc + 2);
            tick();
            success = 0; data_strobe = 0;
            done = 1;
         end else begin
            repeat (hold) tick();
            data_strobe = 0;
            tick();
         end
      end
      if (!done) begin
         if (good) begin
            success = 1;
            if (ep == 0) push_exp(1, n, cyc + 2);
            tick();
            success = 0;
         end else begin
            transaction_active = 0;
            if (ep == 0) push_exp(0, n, cyc + 2);
            tick();
         end
      end
      transaction_active = 0; setup = 0;
      repeat (4) tick();
   endtask

   task automatic do_status_in();
      transaction_active = 1; setup = 0; direction_in = 1; endpoint = 0;
      tick();
      success = 1;
      tick();
      if (m_pending) begin
         m_addr = m_pend_addr;
         m_pending = 0;
      end
      chk("status_addr", {25'd0, usb_address}, {25'd0, m_addr});
      chk("status_pend", {31'd0, addr_pending}, {31'd0, m_pending});
      success = 0; transaction_active = 0; direction_in = 0;
      repeat (2) tick();
   endtask

   task automatic check_addr(input string tag);
      chk({tag, "_addr"}, {25'd0, usb_address}, {25'd0, m_addr});
      chk({tag, "_pend"}, {31'd0, addr_pending}, {31'd0, m_pending});
   endtask

   task automatic load_pkt(input logic [63:0] v);
      // v holds byte 0 in the most significant position
      for (int i = 0; i < 8; i++) pkt[i] = v[63 - 8*i -: 8];
      pkt[8] = 8'hA5; pkt[9] = 8'h5A;
   endtask

   // Monitor: every pulse must match the head of the scoreboard
   always @(negedge clk_48) begin
      if (!rst && (setup_valid || setup_error)) begin
         if (setup_valid && setup_error) begin
            errors++;
            $display("FAIL both_pulses: valid=1 error=1 expected one only");
         end
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: valid=%0b error=%0b at cyc %0d, expected none",
                     setup_valid, setup_error, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind", {31'd0, setup_valid}, {31'd0, e.is_valid});
            chk("pulse_cyc", cyc, e.cyc);
            chk("bm", {24'd0, bm_request_type}, {24'd0, e.bm});
            chk("breq", {24'd0, b_request}, {24'd0, e.br});
            chk("wval", {16'd0, w_value}, {16'd0, e.wv});
            chk("widx", {16'd0, w_index}, {16'd0, e.wi});
            chk("wlen", {16'd0, w_length}, {16'd0, e.wl});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_48);
      #1;
      chk("rst_valid", {31'd0, setup_valid}, 0);
      chk("rst_error", {31'd0, setup_error}, 0);
      chk("rst_bm", {24'd0, bm_request_type}, 0);
      chk("rst_wlen", {16'd0, w_length}, 0);
      chk("rst_addr", {25'd0, usb_address}, 0);
      chk("rst_pend", {31'd0, addr_pending}, 0);
      rst = 0;
      repeat (2) tick();

      // GET_DESCRIPTOR
      load_pkt(64'h8006_0001_0000_4000);
      do_setup(8, 0, 1, 1, 0);
      chk("gd_wvalue", {16'd0, w_value}, 32'h0100);
      chk("gd_wlength", {16'd0, w_length}, 32'h0040);

      // SET_ADDRESS 0x2A, then status stage
      load_pkt(64'h0005_2A00_0000_0000);
      do_setup(8, 0, 1, 1, 1);
      check_addr("sa_after_setup");
      do_status_in();
      chk("sa_addr2a", {25'd0, usb_address}, 32'h2A);

      // Short and long packets, then a failed (no success) packet
      load_pkt(64'h1122_3344_5566_7788);
      do_setup(7, 0, 1, 1, 0);
      do_setup(9, 0, 2, 1, 0);
      do_setup(8, 0, 1, 0, 0);
      // Strobe held for 3 clocks per byte
      load_pkt(64'hC1D2_E3F4_0516_2738);
      do_setup(8, 0, 3, 1, 0);
      // Non-zero endpoint is ignored
      load_pkt(64'h0005_1100_0000_0000);
      do_setup(8, 3, 1, 1, 0);
      check_addr("ep3");

      // usb_rst while an address is set
      usb_rst = 1; tick(); usb_rst = 0;
      m_addr = 0; m_pending = 0;
      tick();
      check_addr("usbrst");

      // usb_rst in the middle of a capture: no pulse afterwards
      load_pkt(64'h0005_3300_0000_0000);
      transaction_active = 1; setup = 1; tick();
      for (int i = 0; i < 8; i++) begin
         data_out = pkt[i]; data_strobe = 1; tick();
         data_strobe = 0;
         if (i == 3) usb_rst = 1;
         tick();
         usb_rst = 0;
      end
      success = 1; tick(); success = 0;
      transaction_active = 0; setup = 0;
      repeat (4) tick();
      check_addr("usbrst_mid");

      // Async reset in the middle of a capture
      transaction_active = 1; setup = 1; tick();
      for (int i = 0; i < 8; i++) begin
         data_out = pkt[i]; data_strobe = 1; tick();
         data_strobe = 0;
         if (i == 2) begin
            #3 rst = 1; #5 rst = 0;
            m_bm = 0; m_br = 0; m_wv = 0; m_wi = 0; m_wl = 0;
            m_addr = 0; m_pending = 0;
         end
         tick();
      end
      success = 1; tick(); success = 0;
      transaction_active = 0; setup = 0;
      repeat (4) tick();
      chk("rstmid_bm", {24'd0, bm_request_type}, {24'd0, m_bm});
      check_addr("rstmid");

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         int op, n, ep, hold, r;
         bit good, same;
         op = $urandom_range(0, 9);
         if (op < 2) begin
            do_status_in();
         end else begin
            r = $urandom_range(0, 5);
            n = (r == 0) ? 7 : (r == 1) ? 9 : 8;
            ep = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0;
            hold = $urandom_range(1, 3);
            good = ($urandom_range(0, 4) != 0);
            same = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 10; i++) pkt[i] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
               pkt[0] = 8'h00; pkt[1] = 8'h05;
            end
            do_setup(n, ep, hold, good, same);
         end
         check_addr("rand");
      end

      repeat (5) tick();
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
